ws_a_skewer: RTL

WS_A_SKEWER -- requirements
Module: ws_a_skewer

---
 rtl/ws_a_skewer_pkg.sv | 19 +
 rtl/ws_a_skewer_lane.sv | 30 +++
 rtl/ws_a_skewer.sv | 89 ++++++++
 3 files changed

// File: rtl/ws_a_skewer_pkg.sv
// Shared types and constants for the A-operand skewer feeding the systolic array.
package ws_a_skewer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } skew_state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefRows      = 4;
  localparam int unsigned DefCols      = 4;

  // Advances needed after the last vector until the far corner PE has consumed it.
  function automatic int unsigned drain_cycles(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/ws_a_skewer_lane.sv
// DEPTH-stage shift register for one skewed row lane; moves only when shift_i is high.
module skew_lane #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (shift_i) begin
      stage_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ws_a_skewer.sv
// Skews incoming A vectors across array rows (row k delayed k+1 advances) and drains the array.
module ws_a_skewer
  import ws_a_skewer_pkg::*;
#(
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic [ROWS*DATA_WIDTH-1:0] a_lane,
  output logic                       m_enable,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DrainCycles = drain_cycles(ROWS, COLS);
  localparam int unsigned CntW        = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  skew_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            accept;
  logic            advance;

  assign s_ready  = ~rst & (state_q != StDrain);
  assign accept   = s_valid & s_ready;
  assign advance  = accept | (~rst & (state_q == StDrain));
  assign m_enable = advance;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= s_last ? StDrain : StStream;
            cnt_q   <= '0;
          end
        end
        StStream: begin
          if (accept && s_last) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end
        end
        StDrain: begin
          if (cnt_q == CntW'(DrainCycles - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;

    // Bubbles are zeros so PEs see no stray operands while skewing or draining.
    assign lane_in = accept ? s_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_lane #(
      .DEPTH      (k + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .shift_i (advance),
      .din_i   (lane_in),
      .dout_o  (a_lane[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
